// File: rtl/unit1_issue_sched.sv
// In-order issue scheduler for unit1: a small operation FIFO feeding a
// registered issue bundle, with FPU busy stalls and a fixed two-cycle
// branch shadow that either resumes issue or flushes and redirects fetch.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ISSUE   | normal issue from queue head; NOP when empty or FPU-stalled
//  WAIT_B  | first shadow cycle after a CTRL op; unit registers verdict
//  CHECK_B | verdict valid; hazard flushes + redirects, else issue as ISSUE
module unit1_issue_sched #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [13:0]                enq_pc,
  input  logic [5:0]                 enq_ope,
  input  logic [31:0]                enq_ds_val,
  input  logic [31:0]                enq_dt_val,
  input  logic [5:0]                 enq_dd,
  input  logic [15:0]                enq_imm,
  input  logic [4:0]                 enq_opr,
  input  logic [3:0]                 enq_ctrl,
  input  logic [6:0]                 is_busy,
  input  logic                       b_is_hazard,
  input  logic [13:0]                b_addr,
  output logic [13:0]                iss_pc,
  output logic [5:0]                 iss_ope,
  output logic [31:0]                iss_ds_val,
  output logic [31:0]                iss_dt_val,
  output logic [5:0]                 iss_dd,
  output logic [15:0]                iss_imm,
  output logic [4:0]                 iss_opr,
  output logic [3:0]                 iss_ctrl,
  output logic                       redirect_valid,
  output logic [13:0]                redirect_addr,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [31:0]                perf_issued,
  output logic [15:0]                perf_flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT_B, CHECK_B} state_t;

  typedef struct packed {
    logic [13:0] pc;
    logic [5:0]  ope;
    logic [31:0] ds_val;
    logic [31:0] dt_val;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [4:0]  opr;
    logic [3:0]  ctrl;
  } op_t;

  state_t        state_q, state_d;
  op_t           mem_q [DEPTH];
  op_t           iss_q, iss_d;
  op_t           enq_op, head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   perf_issued_q, perf_issued_d;
  logic [15:0]   perf_flush_q, perf_flush_d;
  logic          push, pop, flush, hazard, can_issue;

  assign enq_op = '{pc: enq_pc, ope: enq_ope, ds_val: enq_ds_val, dt_val: enq_dt_val,
                    dd: enq_dd, imm: enq_imm, opr: enq_opr, ctrl: enq_ctrl};
  assign head   = mem_q[rd_q];

  assign enq_ready = (count_q < DEPTH_C) && (state_q == ISSUE);
  assign push      = enq_valid && enq_ready;
  // The unit never resets its verdict, so it only counts while in CHECK_B.
  assign hazard    = (state_q == CHECK_B) && b_is_hazard;
  assign can_issue = (count_q != '0) && !((head.ope[1:0] == 2'b01) && (|is_busy));

  assign redirect_valid = hazard;
  assign redirect_addr  = b_addr;

  // Next-state, pop/flush decision and counter updates.
  always_comb begin
    state_d       = state_q;
    iss_d         = '0;
    pop           = 1'b0;
    flush         = 1'b0;
    perf_issued_d = perf_issued_q;
    perf_flush_d  = perf_flush_q;
    case (state_q)
      ISSUE, CHECK_B: begin
        state_d = ISSUE;
        if (hazard) begin
          flush = 1'b1;
          if (perf_flush_q != 16'hFFFF) perf_flush_d = perf_flush_q + 16'd1;
        end else if (can_issue) begin
          iss_d         = head;
          pop           = 1'b1;
          perf_issued_d = perf_issued_q + 32'd1;
          if (head.ope[1:0] == 2'b10) state_d = WAIT_B;
        end
      end
      WAIT_B:  state_d = CHECK_B;
      default: state_d = ISSUE;
    endcase

    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  // State, pointers, issue bundle and counters; reset drops any enqueue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ISSUE;
      wr_q          <= '0;
      rd_q          <= '0;
      count_q       <= '0;
      iss_q         <= '0;
      perf_issued_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      count_q       <= count_d;
      iss_q         <= iss_d;
      perf_issued_q <= perf_issued_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  // Queue storage; contents are don't-care once pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= enq_op;
  end

  assign iss_pc      = iss_q.pc;
  assign iss_ope     = iss_q.ope;
  assign iss_ds_val  = iss_q.ds_val;
  assign iss_dt_val  = iss_q.dt_val;
  assign iss_dd      = iss_q.dd;
  assign iss_imm     = iss_q.imm;
  assign iss_opr     = iss_q.opr;
  assign iss_ctrl    = iss_q.ctrl;
  assign q_count     = count_q;
  assign perf_issued = perf_issued_q;
  assign perf_flush  = perf_flush_q;

endmodule
